// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Purpose  : Sending (source-domain) end of a 4-phase req/ack clock-domain
//            crossing for a multi-bit word. A word is taken over a
//            valid/ready handshake. It is held on o_data while a level
//            request o_req travels to the destination domain. The returning
//            acknowledge is asynchronous and passes through an NSTAGES-deep
//            synchronizer. Every FSM decision uses the synchronized copy only.
// Ports    : i_clk, i_rst_n (async, active-low)   clock / reset
//            i_valid, i_data, o_ready              word intake
//            o_req, o_data                         request level + held word
//            i_ack_async                           acknowledge (other domain)
//            o_done                                one-cycle completion pulse
//            o_err, i_err_clr                      sticky timeout flag / clear
//                                                  (CDC_TX_TIMEOUT_EN only)
// Options  : define CDC_TX_TIMEOUT_EN to bound each ack wait to TIMEOUT_CYC.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NSTAGES     = 2,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_req,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ack_async,
  output logic              o_done
`ifdef CDC_TX_TIMEOUT_EN
  ,
  output logic              o_err,
  input  logic              i_err_clr
`endif
);

  // Elaboration-time parameter sanity checks.
  if (NSTAGES < 2) begin : g_nstages_check
    $error("cdc_handshake_tx: NSTAGES must be >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_timeout_check
    $error("cdc_handshake_tx: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NSTAGES-1:0]  ack_sync_q;

  logic w_ack_s;
  logic w_accept;
  logic w_tmo_hit;
  logic w_abort;

  // Ack synchronizer: bit 0 takes the asynchronous input, and the last bit
  // is the only copy the FSM ever looks at.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[NSTAGES-2:0], i_ack_async};
    end
  end

  assign w_ack_s = ack_sync_q[NSTAGES-1];

  // A stale high ack means the far end has not released the previous
  // transfer yet, so no new word may be taken.
  assign o_ready  = (state_q == ST_IDLE) && !w_ack_s;
  assign w_accept = i_valid && o_ready;

`ifdef CDC_TX_TIMEOUT_EN
  localparam int unsigned        c_cnt_w    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYC - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               abort_q, abort_d;

  // The count would reach TIMEOUT_CYC on this edge.
  assign w_tmo_hit = (cnt_q == c_tmo_last);
  // A handshake whose REQ phase timed out never reports o_done.
  assign w_abort   = abort_q;
`else
  assign w_tmo_hit = 1'b0;
  assign w_abort   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    err_d   = err_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          data_d  = i_data;
          req_d   = 1'b1;
          state_d = ST_REQ;
`ifdef CDC_TX_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        if (w_ack_s) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
        end else if (w_tmo_hit) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
`ifdef CDC_TX_TIMEOUT_EN
          err_d   = 1'b1;
          abort_d = 1'b1;
`endif
        end
      end
      ST_RELEASE: begin
        if (!w_ack_s) begin
          done_d  = !w_abort;
          state_d = ST_IDLE;
        end else if (w_tmo_hit) begin
          state_d = ST_IDLE;
`ifdef CDC_TX_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
`ifdef CDC_TX_TIMEOUT_EN
    // Count time spent in the current waiting state; restart on any move.
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Clear has priority over a timeout raised in the same cycle.
    if (i_err_clr) begin
      err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign o_err = err_q;
`endif

  assign o_req  = req_q;
  assign o_data = data_q;
  assign o_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Purpose  : Self-checking bench for cdc_handshake_tx. Transfer schedules are
//            planned transaction by transaction from the protocol timing
//            rules: accept, ack seen NSTAGES edges later, req drop / done one
//            edge after that. The plan is expanded into per-cycle expected
//            outputs and the stimulus for each cycle. The same planner
//            produces the directed cases (basic, back-to-back, stale ack)
//            and the randomized rounds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

  localparam int N    = 2;
  localparam int DW   = 8;
`ifdef CDC_TX_TIMEOUT_EN
  localparam int TMO  = 15;
`else
  localparam int TMO  = 1023;
`endif
  localparam int MAXC = 400;
  localparam int MAXT = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          ack   = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready, req, done;
  logic [DW-1:0] data_out;
`ifdef CDC_TX_TIMEOUT_EN
  logic          err;
  logic          err_clr = 1'b0;
`endif

  cdc_handshake_tx #(
    .DATA_W(DW), .NSTAGES(N), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data_in),
    .o_ready(ready), .o_req(req), .o_data(data_out),
    .i_ack_async(ack), .o_done(done)
`ifdef CDC_TX_TIMEOUT_EN
    , .o_err(err), .i_err_clr(err_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction plan
  int            ntx;
  int            stale;
  int            vofs [MAXT];
  int            l1   [MAXT];
  int            l2   [MAXT];
  logic [DW-1:0] word [MAXT];

  // Per-cycle stimulus and expectations
  int            ncyc;
  bit            d_val [MAXC];
  bit            d_ack [MAXC];
  logic [DW-1:0] d_dat [MAXC];
  bit            e_req [MAXC];
  bit            e_rdy [MAXC];
  bit            e_done[MAXC];
  logic [DW-1:0] e_data[MAXC];

  // Expand the plan. For transaction k: valid goes up vofs cycles after the
  // previous accept. Accept happens in the first cycle that is idle with the
  // synchronized ack low. The responder raises ack l1 cycles after it sees
  // req. It drops ack l2 cycles after req has fallen.
  task automatic build();
    int idle_from, prev_a, a, r, f, v;
    for (int c = 0; c < MAXC; c++) begin
      e_req[c] = 0; e_done[c] = 0; e_rdy[c] = 0; e_data[c] = '0;
      d_val[c] = 0; d_ack[c] = 0; d_dat[c] = DW'($urandom);
    end
    idle_from = 0;
    if (stale > 0) begin
      for (int c = 0; c < stale; c++) d_ack[c] = 1;
      for (int c = 0; c < N; c++) e_rdy[c] = 1;
      idle_from = stale + N;
    end
    prev_a = -1;
    for (int k = 0; k < ntx; k++) begin
      v = prev_a + 1 + vofs[k];
      a = (v > idle_from) ? v : idle_from;
      for (int c = idle_from; c <= a; c++) e_rdy[c] = 1;
      for (int c = v; c <= a; c++) begin d_val[c] = 1; d_dat[c] = word[k]; end
      r = a + 1 + l1[k];
      f = r + N + 1 + l2[k];
      for (int c = a + 1; c <= r + N; c++) e_req[c] = 1;
      for (int c = r; c < f; c++) d_ack[c] = 1;
      e_done[f + N + 1] = 1;
      for (int c = a + 1; c < MAXC; c++) e_data[c] = word[k];
      idle_from = f + N + 1;
      prev_a    = a;
    end
    ncyc = idle_from + 4;
    for (int c = idle_from; c < ncyc; c++) e_rdy[c] = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; ack = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_sched(input string ph);
    for (int c = 0; c < ncyc; c++) begin
      valid = d_val[c]; data_in = d_dat[c]; ack = d_ack[c];
      @(negedge clk);
      chk($sformatf("%s req@%0d", ph, c),   req,      e_req[c]);
      chk($sformatf("%s rdy@%0d", ph, c),   ready,    e_rdy[c]);
      chk($sformatf("%s done@%0d", ph, c),  done,     e_done[c]);
      chk($sformatf("%s data@%0d", ph, c),  data_out, e_data[c]);
`ifdef CDC_TX_TIMEOUT_EN
      chk($sformatf("%s err@%0d", ph, c),   err,      1'b0);
`endif
      @(posedge clk); #1;
    end
    valid = 1'b0; ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic transfer: A5 accepted at cycle 0, ack up at 5 and down at 12.
    do_reset();
    stale = 0; ntx = 1;
    vofs[0] = 0; l1[0] = 4; l2[0] = 4; word[0] = 8'hA5;
    build();
    run_sched("basic");

    // Back-to-back: valid held high; second word taken in the done cycle.
    do_reset();
    stale = 0; ntx = 2;
    vofs[0] = 0; l1[0] = 3; l2[0] = 3; word[0] = 8'h11;
    vofs[1] = 0; l1[1] = 3; l2[1] = 3; word[1] = 8'h22;
    build();
    run_sched("b2b");

    // Randomized rounds; round 0 starts with a stale ack out of reset.
    for (int rnd = 0; rnd < 3; rnd++) begin
      do_reset();
      stale = (rnd == 0) ? int'($urandom_range(1, 4)) : 0;
      ntx   = 12;
      for (int k = 0; k < ntx; k++) begin
        vofs[k] = $urandom_range(0, 6);
        l1[k]   = $urandom_range(0, 3);
        l2[k]   = $urandom_range(0, 3);
        word[k] = DW'($urandom);
      end
      if (stale > 0) vofs[0] = N;
      build();
      run_sched($sformatf("rnd%0d", rnd));
    end

    // Asynchronous reset while the request is up.
    do_reset();
    valid = 1'b1; data_in = 8'h5A; ack = 1'b0;
    @(posedge clk); #1 valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid pre req",  req,      1'b1);
    chk("rstmid pre data", data_out, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid req",   req,      1'b0);
    chk("rstmid data",  data_out, 8'h00);
    chk("rstmid done",  done,     1'b0);
    chk("rstmid ready", ready,    1'b1);

`ifdef CDC_TX_TIMEOUT_EN
    // Timeout: ack never rises. req drops after TMO cycles in REQ, err is
    // raised, no done follows, and clear in cycle 20 drops err.
    do_reset();
    for (int c = 0; c < 27; c++) begin
      valid   = (c == 0);
      data_in = (c == 0) ? 8'hC3 : DW'($urandom);
      err_clr = (c == 20);
      ack     = 1'b0;
      @(negedge clk);
      chk($sformatf("tmo req@%0d", c),  req,      (c >= 1 && c <= TMO));
      chk($sformatf("tmo err@%0d", c),  err,      (c >= TMO + 1 && c <= 20));
      chk($sformatf("tmo done@%0d", c), done,     1'b0);
      chk($sformatf("tmo rdy@%0d", c),  ready,    (c == 0 || c >= TMO + 2));
      chk($sformatf("tmo data@%0d", c), data_out, (c >= 1) ? 8'hC3 : 8'h00);
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
